// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encoding and FSM states.
package mdu_pkg;

  localparam int unsigned MDU_OP_W  = 4;
  localparam int unsigned MDU_MULT  = 0;
  localparam int unsigned MDU_MULTU = 1;
  localparam int unsigned MDU_DIV   = 2;
  localparam int unsigned MDU_DIVU  = 3;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StFix,
    StDone
  } mdu_state_e;

endpackage

// File: rtl/mdu_iter_if.sv
// Operand/result handshake bundle between the datapath (master) and mdu_iter (slave).
interface mdu_iter_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  import mdu_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic [MDU_OP_W-1:0]   op;
  logic [DATA_WIDTH-1:0] a;
  logic [DATA_WIDTH-1:0] b;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_hi;
  logic [DATA_WIDTH-1:0] out_lo;
  logic                  out_dz;
  logic                  out_err;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, out_hi, out_lo, out_dz, out_err
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, out_hi, out_lo, out_dz, out_err
  );

endinterface

// File: rtl/mdu_negate.sv
// Combinational conditional two's-complement negation.
module mdu_negate #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] in_i,
  input  logic             neg_i,
  output logic [WIDTH-1:0] out_o
);

  assign out_o = neg_i ? (~in_i + WIDTH'(1)) : in_i;

endmodule

// File: rtl/mdu_iter.sv
// Iterative signed/unsigned multiply and divide, one bit per cycle, with a single shared
// W+1-bit adder. Signed ops run on magnitudes and are sign-corrected in the FIX cycle.
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input logic       clk,
  input logic       rst_n,
  input logic       flush,
  mdu_iter_if.slave bus
);

  localparam int unsigned W    = DATA_WIDTH;
  localparam int unsigned CntW = $clog2(DATA_WIDTH) + 1;

  mdu_state_e      state_q;
  logic [CntW-1:0] cnt_q;
  logic            is_div_q;
  logic            neg_lo_q;
  logic            neg_hi_q;
  logic [2*W-1:0]  acc_q;
  logic [W-1:0]    opd_q;
  logic [W-1:0]    out_hi_q;
  logic [W-1:0]    out_lo_q;
  logic            out_dz_q;
  logic            out_err_q;

  // Accept-side decode and operand magnitudes
  logic         op_legal, signed_in, is_div_in, neg_a_in, neg_b_in;
  logic [W-1:0] mag_a, mag_b;

  assign op_legal  = $onehot(bus.op);
  assign signed_in = bus.op[MDU_MULT] | bus.op[MDU_DIV];
  assign is_div_in = bus.op[MDU_DIV] | bus.op[MDU_DIVU];
  assign neg_a_in  = signed_in & bus.a[W-1];
  assign neg_b_in  = signed_in & bus.b[W-1];

  mdu_negate #(.WIDTH(W)) u_mag_a (.in_i(bus.a), .neg_i(neg_a_in), .out_o(mag_a));
  mdu_negate #(.WIDTH(W)) u_mag_b (.in_i(bus.b), .neg_i(neg_b_in), .out_o(mag_b));

  // Shared adder: multiply adds the multiplicand, divide subtracts the divisor
  logic [W:0]     add_x, add_y, add_sum;
  logic [2*W-1:0] acc_step;

  always_comb begin
    if (is_div_q) begin
      add_x = {acc_q[2*W-1:W], acc_q[W-1]};
      add_y = ~{1'b0, opd_q};
    end else begin
      add_x = {1'b0, acc_q[2*W-1:W]};
      add_y = {1'b0, opd_q};
    end
  end

  assign add_sum = add_x + add_y + {{W{1'b0}}, is_div_q};

  always_comb begin
    acc_step = acc_q;
    if (is_div_q) begin
      // Non-negative trial difference keeps the subtraction and shifts in a 1
      if (!add_sum[W]) acc_step = {add_sum[W-1:0], acc_q[W-2:0], 1'b1};
      else             acc_step = {acc_q[2*W-2:0], 1'b0};
    end else begin
      if (acc_q[0]) acc_step = {add_sum, acc_q[W-1:1]};
      else          acc_step = {1'b0, acc_q[2*W-1:1]};
    end
  end

  // Sign fix-up of the finished result
  logic [2*W-1:0] prod_fix;
  logic [W-1:0]   quo_fix, rem_fix;

  mdu_negate #(.WIDTH(2*W)) u_fix_prod (.in_i(acc_q), .neg_i(neg_lo_q), .out_o(prod_fix));
  mdu_negate #(.WIDTH(W)) u_fix_quo (.in_i(acc_q[W-1:0]), .neg_i(neg_lo_q), .out_o(quo_fix));
  mdu_negate #(.WIDTH(W)) u_fix_rem (.in_i(acc_q[2*W-1:W]), .neg_i(neg_hi_q), .out_o(rem_fix));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_lo_q  <= 1'b0;
      neg_hi_q  <= 1'b0;
      acc_q     <= '0;
      opd_q     <= '0;
      out_hi_q  <= '0;
      out_lo_q  <= '0;
      out_dz_q  <= 1'b0;
      out_err_q <= 1'b0;
    end else if (flush) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.in_valid) begin
            is_div_q <= is_div_in;
            neg_lo_q <= neg_a_in ^ neg_b_in;
            neg_hi_q <= neg_a_in;
            cnt_q    <= '0;
            if (!op_legal) begin
              state_q   <= StDone;
              out_hi_q  <= '0;
              out_lo_q  <= '0;
              out_dz_q  <= 1'b0;
              out_err_q <= 1'b1;
            end else if (is_div_in && (bus.b == '0)) begin
              state_q   <= StDone;
              out_hi_q  <= bus.a;
              out_lo_q  <= '1;
              out_dz_q  <= 1'b1;
              out_err_q <= 1'b0;
            end else begin
              state_q <= StCalc;
              acc_q   <= {{W{1'b0}}, (is_div_in ? mag_a : mag_b)};
              opd_q   <= is_div_in ? mag_b : mag_a;
            end
          end
        end
        StCalc: begin
          acc_q <= acc_step;
          if (cnt_q == CntW'(W - 1)) begin
            state_q <= StFix;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StFix: begin
          if (is_div_q) begin
            out_hi_q <= rem_fix;
            out_lo_q <= quo_fix;
          end else begin
            {out_hi_q, out_lo_q} <= prod_fix;
          end
          out_dz_q  <= 1'b0;
          out_err_q <= 1'b0;
          state_q   <= StDone;
        end
        StDone: begin
          if (bus.out_ready) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign bus.out_hi    = out_hi_q;
  assign bus.out_lo    = out_lo_q;
  assign bus.out_dz    = out_dz_q;
  assign bus.out_err   = out_err_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: directed corner cases plus randomized ops against an
// arithmetic reference model.
module tb_mdu_iter;
  import mdu_pkg::*;

  localparam int unsigned W = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;

  always #5 clk = ~clk;

  mdu_iter_if #(.DATA_WIDTH(W)) bus ();

  mdu_iter #(.DATA_WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .flush(flush),
    .bus  (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Result from plain signed/unsigned 64-bit arithmetic; lat is edges after accept to valid.
  task automatic model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                       output logic [31:0] hi, output logic [31:0] lo, output logic dz,
                       output logic err, output int lat);
    longint          sx, sy, sp;
    longint unsigned ux, uy, up;
    sx  = longint'($signed(x));
    sy  = longint'($signed(y));
    ux  = {32'b0, x};
    uy  = {32'b0, y};
    hi  = '0;
    lo  = '0;
    dz  = 1'b0;
    err = 1'b0;
    lat = W + 1;
    if ($countones(o) != 1) begin
      err = 1'b1;
      lat = 0;
    end else if (o[MDU_MULT]) begin
      sp = sx * sy;
      {hi, lo} = sp;
    end else if (o[MDU_MULTU]) begin
      up = ux * uy;
      {hi, lo} = up;
    end else if (y == 0) begin
      dz  = 1'b1;
      lo  = '1;
      hi  = x;
      lat = 0;
    end else if (o[MDU_DIV]) begin
      lo = 32'(sx / sy);
      hi = 32'(sx % sy);
    end else begin
      lo = 32'(ux / uy);
      hi = 32'(ux % uy);
    end
  endtask

  // Issue one op from IDLE, measure latency, check a one-cycle stall hold, then hand off.
  task automatic issue(input string tag, input logic [3:0] o, input logic [31:0] x,
                       input logic [31:0] y, output int lat, output logic [31:0] hi,
                       output logic [31:0] lo, output logic dz, output logic err);
    int n;
    check({tag, ".in_ready"}, 64'(bus.in_ready), 64'(1));
    bus.in_valid = 1'b1;
    bus.op       = o;
    bus.a        = x;
    bus.b        = y;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    lat = n;
    hi  = bus.out_hi;
    lo  = bus.out_lo;
    dz  = bus.out_dz;
    err = bus.out_err;
    @(posedge clk);
    #1;
    check({tag, ".hold"}, 64'(bus.out_valid && bus.out_hi == hi && bus.out_lo == lo), 64'(1));
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check({tag, ".release"}, 64'({bus.in_ready, bus.out_valid}), 64'(2'b10));
  endtask

  task automatic exercise(input string tag, input logic [3:0] o, input logic [31:0] x,
                          input logic [31:0] y);
    logic [31:0] ehi, elo, ghi, glo;
    logic        edz, eerr, gdz, gerr;
    int          elat, glat;
    model(o, x, y, ehi, elo, edz, eerr, elat);
    issue(tag, o, x, y, glat, ghi, glo, gdz, gerr);
    check({tag, ".lat"}, 64'(glat), 64'(elat));
    check({tag, ".hi"}, 64'(ghi), 64'(ehi));
    check({tag, ".lo"}, 64'(glo), 64'(elo));
    check({tag, ".dz"}, 64'(gdz), 64'(edz));
    check({tag, ".err"}, 64'(gerr), 64'(eerr));
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'h8000_0000;
      3:       return 32'hFFFF_FFFF;
      default: return 32'($urandom());
    endcase
  endfunction

  task automatic wait_no_valid(input string tag);
    int seen;
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen++;
    end
    check(tag, 64'(seen), 64'(0));
  endtask

  initial begin
    logic [31:0] ehi, elo, cap_hi, cap_lo, x, y;
    logic        edz, eerr;
    int          elat, n, bad, r;
    logic [3:0]  o;

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.op        = '0;
    bus.a         = '0;
    bus.b         = '0;

    #12;
    check("rst.in_ready", 64'(bus.in_ready), 64'(1));
    check("rst.out_valid", 64'(bus.out_valid), 64'(0));
    check("rst.hi_lo", {bus.out_hi, bus.out_lo}, 64'(0));
    check("rst.flags", 64'({bus.out_dz, bus.out_err}), 64'(0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    exercise("mult_neg1x2", 4'b0001, 32'hFFFF_FFFF, 32'h0000_0002);
    exercise("multu_max_x2", 4'b0010, 32'hFFFF_FFFF, 32'h0000_0002);
    exercise("divu_7_2", 4'b1000, 32'd7, 32'd2);
    exercise("div_m7_2", 4'b0100, 32'hFFFF_FFF9, 32'd2);
    exercise("div_min_m1", 4'b0100, 32'h8000_0000, 32'hFFFF_FFFF);
    exercise("divu_5_0", 4'b1000, 32'd5, 32'd0);
    exercise("illegal_0011", 4'b0011, 32'd9, 32'd3);
    exercise("illegal_0000", 4'b0000, 32'd9, 32'd3);
    exercise("div_7_m2", 4'b0100, 32'd7, 32'hFFFF_FFFE);

    // Flush mid-CALC, with in_valid raised in the flush cycle
    bus.in_valid = 1'b1;
    bus.op       = 4'b0010;
    bus.a        = 32'd1234;
    bus.b        = 32'd5678;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check("flush.busy", 64'(bus.in_ready), 64'(0));
    repeat (4) @(posedge clk);
    #1;
    flush        = 1'b1;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    check("flush.idle", 64'({bus.in_ready, bus.out_valid}), 64'(2'b10));
    @(posedge clk);
    #1;
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    check("flush.no_accept", 64'(bus.in_ready), 64'(1));
    wait_no_valid("flush.no_valid");
    exercise("post_flush", 4'b0010, 32'd3, 32'd4);

    // Asynchronous reset mid-CALC
    bus.in_valid = 1'b1;
    bus.op       = 4'b0001;
    bus.a        = 32'd77;
    bus.b        = 32'd99;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst.idle", 64'({bus.in_ready, bus.out_valid}), 64'(2'b10));
    check("arst.hi_lo", {bus.out_hi, bus.out_lo}, 64'(0));
    #4;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    wait_no_valid("arst.no_valid");
    exercise("post_rst", 4'b0010, 32'd3, 32'd4);

    // Backpressure with in_valid held high through DONE
    model(4'b0010, 32'h0001_0001, 32'h30, ehi, elo, edz, eerr, elat);
    bus.in_valid = 1'b1;
    bus.op       = 4'b0010;
    bus.a        = 32'h0001_0001;
    bus.b        = 32'h30;
    @(posedge clk);
    #1;
    bus.op = 4'b1000;
    bus.a  = 32'd100;
    bus.b  = 32'd7;
    n = 0;
    while (!bus.out_valid && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("bp.lat", 64'(n), 64'(elat));
    check("bp.result", {bus.out_hi, bus.out_lo}, {ehi, elo});
    cap_hi = bus.out_hi;
    cap_lo = bus.out_lo;
    bad    = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (bus.in_ready || !bus.out_valid || bus.out_hi != cap_hi || bus.out_lo != cap_lo) bad++;
    end
    check("bp.stable", 64'(bad), 64'(0));
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check("bp.ready_after", 64'({bus.in_ready, bus.out_valid}), 64'(2'b10));
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check("bp.accepted", 64'(bus.in_ready), 64'(0));
    model(4'b1000, 32'd100, 32'd7, ehi, elo, edz, eerr, elat);
    n = 0;
    while (!bus.out_valid && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("bp.second_lat", 64'(n), 64'(elat));
    check("bp.second_result", {bus.out_hi, bus.out_lo}, {ehi, elo});
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;

    // Randomized ops including illegal encodings and zero divisors
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      x = pick();
      y = pick();
      if (r < 8) begin
        o = 4'(1 << (r % 4));
      end else if (r == 8) begin
        o = 4'($urandom_range(0, 15));
        if ($countones(o) == 1) o = 4'b1100;
      end else begin
        o = ($urandom_range(0, 1) == 0) ? 4'b0100 : 4'b1000;
        y = 32'd0;
      end
      exercise($sformatf("rnd%0d_op%0h", i, o), o, x, y);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
